fb_frame_reader: RTL and testbench

//  Read-side counterpart of the frame-buffer write mux: scans one frame out of the 12-bit pixel BRAM
//  in raster order and delivers it as a valid/ready pixel stream to the Gaussian filter or display.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_rd_fifo.sv | 55 +++++
 rtl/fb_frame_reader.sv | 155 +++++++++++++++
 tb/tb_fb_frame_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the frame-buffer read path.
package fb_pkg;

    localparam int DEF_FRAME_W = 320;
    localparam int DEF_FRAME_H = 240;
    localparam int DEF_ADDR_W  = 18;
    localparam int DEF_DATA_W  = 12;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    // Side-band carried alongside each outstanding BRAM read.
    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
    } rdTag_t;

endpackage

// File: rtl/fb_rd_fifo.sv
// fb_rd_fifo: small synchronous first-word-fall-through FIFO with occupancy count.
module fb_rd_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushEn,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popEn,
    output logic [WIDTH-1:0] headData,
    output logic             headValid,
    output logic [CNT_W-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr, rdPtr;
    logic [CNT_W-1:0] cnt;
    logic             doPush, doPop;

    // Pop only a present word; a push into a full FIFO is allowed only alongside a pop.
    assign doPop  = popEn && (cnt != '0);
    assign doPush = pushEn && ((cnt != FULL_CNT) || doPop);

    assign headData  = mem[rdPtr];
    assign headValid = (cnt != '0);
    assign count     = cnt;

    // Storage array: no reset needed, validity is tracked by cnt.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    // Pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PW'(1);
            if (doPop)  rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fb_frame_reader.sv
// fb_frame_reader: raster scan-out of one frame from the pixel BRAM into a valid/ready stream.
module fb_frame_reader
    import fb_pkg::*;
#(
    parameter int FRAME_W    = DEF_FRAME_W,
    parameter int FRAME_H    = DEF_FRAME_H,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              RdEn,
    input  logic [DATA_W-1:0] RdDout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol
);
    localparam int XW  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int YW  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam int FW  = DATA_W + 2;

    localparam logic [XW-1:0] LAST_COL  = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] LAST_LINE = YW'(FRAME_H - 1);

    rd_state_t         state, stateNext;
    logic [ADDR_W-1:0] rdAddrQ, addrNext;
    logic [XW-1:0]     colCnt, colNext;
    logic [YW-1:0]     lineCnt, lineNext;
    logic              issueNext;

    // Stage 0 is the read being issued this cycle; stage RD_LAT lines up with RdDout.
    rdTag_t            vldPipe [RD_LAT:0];

    logic [FCW-1:0]    fifoCount;
    logic [FW-1:0]     fifoHead;
    logic              fifoValid;
    logic [CW-1:0]     inflight, occNext;
    logic              rdEn, pop, creditOk, lastIssue, lastPop;

    assign rdEn      = vldPipe[0].vld;
    assign pop       = fifoValid && m_ready;
    assign lastIssue = rdEn && (colCnt == LAST_COL) && (lineCnt == LAST_LINE);
    assign lastPop   = pop && (fifoCount == FCW'(1)) && (inflight == '0);

    // Credit check: words held plus reads outstanding after this cycle must leave room.
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= RD_LAT; i++) inflight = inflight + CW'(vldPipe[i].vld);
        occNext  = CW'(fifoCount) + inflight + CW'(rdEn) - CW'(pop);
        creditOk = (occNext < CW'(FIFO_DEPTH));
    end

    // Next-state, next-address and issue decision for the following cycle.
    always_comb begin
        stateNext = state;
        addrNext  = rdAddrQ;
        colNext   = colCnt;
        lineNext  = lineCnt;
        issueNext = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = READ;
                    addrNext  = '0;
                    colNext   = '0;
                    lineNext  = '0;
                    issueNext = 1'b1;
                end
            end
            READ: begin
                if (lastIssue) begin
                    stateNext = DRAIN;
                end else begin
                    if (rdEn) begin
                        addrNext = rdAddrQ + ADDR_W'(1);
                        if (colCnt == LAST_COL) begin
                            colNext  = '0;
                            lineNext = lineCnt + YW'(1);
                        end else begin
                            colNext = colCnt + XW'(1);
                        end
                    end
                    issueNext = creditOk;
                end
            end
            DRAIN: begin
                if (lastPop) stateNext = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM state and raster counters; address holds at the last pixel after the final issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdAddrQ <= '0;
            colCnt  <= '0;
            lineCnt <= '0;
        end else begin
            state   <= stateNext;
            rdAddrQ <= addrNext;
            colCnt  <= colNext;
            lineCnt <= lineNext;
        end
    end

    // Tag pipe: registers the next issue and shifts tags in step with the BRAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) vldPipe[i] <= '0;
        end else begin
            vldPipe[0] <= '{vld: issueNext, sof: (addrNext == '0), eol: (colNext == LAST_COL)};
            for (int i = 1; i <= RD_LAT; i++) vldPipe[i] <= vldPipe[i-1];
        end
    end

    fb_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCW)
    ) uFifo (
        .clk       (clk),
        .rst       (rst),
        .pushEn    (vldPipe[RD_LAT].vld),
        .pushData  ({RdDout, vldPipe[RD_LAT].sof, vldPipe[RD_LAT].eol}),
        .popEn     (pop),
        .headData  (fifoHead),
        .headValid (fifoValid),
        .count     (fifoCount)
    );

    assign RdEn    = rdEn;
    assign RdAddr  = rdAddrQ;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign m_valid = fifoValid;
    assign m_data  = fifoValid ? fifoHead[FW-1:2] : '0;
    assign m_sof   = fifoValid && fifoHead[1];
    assign m_eol   = fifoValid && fifoHead[0];

endmodule

// File: tb/tb_fb_frame_reader.sv
// tb_fb_frame_reader: five readers (small frames at RD_LAT 1/2/3, full frames at RD_LAT 1/3)
// checked against a pixel-index model of the expected stream.
module tb_fb_frame_reader;

    localparam int N = 5;
    localparam int LATS   [N] = '{1, 2, 3, 1, 3};
    localparam int WS     [N] = '{4, 4, 4, 320, 320};
    localparam int HS     [N] = '{3, 3, 3, 240, 240};
    localparam int DEPTHS [N] = '{4, 4, 4, 4, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sRst, sStart, sReady, bRst, bStart;
    logic [N-1:0]       rst, start, ready, busy, done, rdEn, mValid, mSof, mEol;
    logic [N-1:0][17:0] rdAddr;
    logic [N-1:0][11:0] rdDout, mData;

    assign rst   = {bRst, bRst, sRst, sRst, sRst};
    assign start = {bStart, bStart, sStart, sStart, sStart};
    assign ready = {1'b1, 1'b1, sReady, sReady, sReady};

    for (genvar g = 0; g < N; g++) begin : inst
        // BRAM model: mem[a] = a[11:0], data appears LATS[g] cycles after the address.
        logic [11:0] pipe [1:LATS[g]];
        always @(posedge clk) begin
            pipe[1] <= rdAddr[g][11:0];
            for (int i = 2; i <= LATS[g]; i++) pipe[i] <= pipe[i-1];
        end
        assign rdDout[g] = pipe[LATS[g]];

        fb_frame_reader #(
            .FRAME_W(WS[g]), .FRAME_H(HS[g]), .ADDR_W(18), .DATA_W(12),
            .RD_LAT(LATS[g]), .FIFO_DEPTH(DEPTHS[g])
        ) dut (
            .clk(clk), .rst(rst[g]), .start(start[g]), .busy(busy[g]), .done(done[g]),
            .RdAddr(rdAddr[g]), .RdEn(rdEn[g]), .RdDout(rdDout[g]),
            .m_data(mData[g]), .m_valid(mValid[g]), .m_ready(ready[g]),
            .m_sof(mSof[g]), .m_eol(mEol[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference state per reader
    bit          mBusy [N];
    bit          expDone [N];
    bit          stall [N];
    logic [14:0] held [N];
    int          issued [N];
    int          accepted [N];
    int          startCyc [N];
    int          firstValidCyc [N];
    int          framesDone [N];
    int          lastAddr [N];

    task automatic check(input string tag, input int idx, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < N; i++) begin
            int total;
            bit lastXfer;
            total = WS[i] * HS[i];
            lastXfer = 1'b0;
            if (rst[i]) begin
                mBusy[i] = 0; expDone[i] = 0; stall[i] = 0;
                issued[i] = 0; accepted[i] = 0; firstValidCyc[i] = -2;
            end else begin
                check("busy", i, busy[i], mBusy[i]);
                check("done", i, done[i], expDone[i]);
                if (expDone[i]) check("issuedAtDone", i, issued[i], total);
                if (rdEn[i]) begin
                    check("rdEnWhileBusy", i, mBusy[i], 1);
                    if (issued[i] == 0) check("issueLat", i, cyc - startCyc[i], 1);
                    check("rdAddr", i, rdAddr[i], issued[i]);
                    issued[i]++;
                    lastAddr[i] = int'(rdAddr[i]);
                end
                check("credit", i, (issued[i] - accepted[i]) <= DEPTHS[i], 1);
                if (stall[i]) check("hold", i, {mValid[i], mData[i], mSof[i], mEol[i]}, held[i]);
                if (mValid[i] && firstValidCyc[i] == -1) begin
                    firstValidCyc[i] = cyc;
                    check("validLat", i, cyc - startCyc[i], 2 + LATS[i]);
                end
                if (mValid[i] && ready[i]) begin
                    check("xferInFrame", i, accepted[i] < total, 1);
                    check("data", i, mData[i], accepted[i] % 4096);
                    check("sof", i, mSof[i], accepted[i] == 0);
                    check("eol", i, mEol[i], (accepted[i] % WS[i]) == WS[i] - 1);
                    accepted[i]++;
                    lastXfer = (accepted[i] == total);
                end
                if (expDone[i]) begin
                    mBusy[i] = 0;
                    framesDone[i]++;
                end else if (start[i] && !mBusy[i]) begin
                    mBusy[i] = 1; issued[i] = 0; accepted[i] = 0;
                    startCyc[i] = cyc; firstValidCyc[i] = -1;
                end
                expDone[i] = lastXfer;
                stall[i] = mValid[i] && !ready[i];
                held[i] = {mValid[i], mData[i], mSof[i], mEol[i]};
            end
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkCleared(input int i);
        check("rstOut", i, {busy[i], done[i], rdEn[i], mValid[i], mSof[i], mEol[i], rdAddr[i], mData[i]}, 0);
    endtask

    task automatic waitSmallIdle(input int limit, input bit randReady);
        int n;
        n = 0;
        while ((mBusy[0] || mBusy[1] || mBusy[2]) && n < limit) begin
            if (randReady) sReady = ($urandom_range(0, 9) >= 3);
            step();
            n++;
        end
        sReady = 1'b1;
        check("idleTimeout", 0, n < limit, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            mBusy[i] = 0; expDone[i] = 0; stall[i] = 0; held[i] = '0;
            issued[i] = 0; accepted[i] = 0; startCyc[i] = 0;
            firstValidCyc[i] = -2; framesDone[i] = 0; lastAddr[i] = 0;
        end
        sRst = 1'b1; bRst = 1'b1; sStart = 1'b0; bStart = 1'b0; sReady = 1'b1;
        repeat (3) step();
        for (int i = 0; i < N; i++) checkCleared(i);
        sRst = 1'b0; bRst = 1'b0;
        step();

        // Full-size frames run in the background for the rest of the run.
        bStart = 1'b1; step(); bStart = 1'b0;

        // Frame with the consumer always ready
        sStart = 1'b1; step(); sStart = 1'b0;
        waitSmallIdle(200, 1'b0);
        for (int i = 0; i < 3; i++) check("frames1", i, framesDone[i], 1);

        // Random backpressure, two frames
        repeat (2) begin
            sStart = 1'b1; sReady = ($urandom_range(0, 9) >= 3); step(); sStart = 1'b0;
            waitSmallIdle(600, 1'b1);
        end
        for (int i = 0; i < 3; i++) check("frames2", i, framesDone[i], 3);

        // Consumer stalled for 20 cycles: reads stop at the FIFO depth, head holds pixel 0
        sReady = 1'b0; sStart = 1'b1; step(); sStart = 1'b0;
        repeat (20) step();
        for (int i = 0; i < 3; i++) begin
            check("stallIssued", i, issued[i], DEPTHS[i]);
            check("stallValid", i, mValid[i], 1);
            check("stallData", i, mData[i], 0);
        end
        sReady = 1'b1;
        waitSmallIdle(200, 1'b0);

        // start pulsed during READ and during DONE is ignored
        sStart = 1'b1; step(); sStart = 1'b0;
        repeat (3) step();
        sStart = 1'b1; step(); sStart = 1'b0;
        n = 0;
        while (!expDone[1] && n < 200) begin step(); n++; end
        check("doneTimeout", 1, n < 200, 1);
        sStart = 1'b1; step(); sStart = 1'b0;
        repeat (2) step();
        check("startInDone", 1, busy[1], 0);
        waitSmallIdle(200, 1'b0);
        sStart = 1'b1; step(); sStart = 1'b0;
        waitSmallIdle(200, 1'b0);

        // Reset mid-frame after 5 accepted pixels, then a clean frame
        sStart = 1'b1; step(); sStart = 1'b0;
        n = 0;
        while (accepted[1] < 5 && n < 100) begin step(); n++; end
        check("fiveTimeout", 1, n < 100, 1);
        sRst = 1'b1; step(); sRst = 1'b0;
        for (int i = 0; i < 3; i++) checkCleared(i);
        step();
        sStart = 1'b1; step(); sStart = 1'b0;
        waitSmallIdle(200, 1'b0);

        // Full-size frames
        n = 0;
        while ((mBusy[3] || mBusy[4]) && n < 90000) begin step(); n++; end
        check("bigTimeout", 3, n < 90000, 1);
        for (int i = 3; i < N; i++) begin
            check("bigFrames", i, framesDone[i], 1);
            check("bigPixels", i, accepted[i], 76800);
            check("bigLastAddr", i, lastAddr[i], 76799);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
